// File: rtl/board_mem_arbiter.sv
// Board block memory port owner: arbitrates GPU pixel fetch, row-collapse engine and CPU
// (GPU > collapse > CPU) and runs the engine that shifts the board down after a line clear.
module board_mem_arbiter #(
  parameter int ROWS   = 20,
  parameter int COLS   = 10,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gpu_rd_en,
  input  logic [ADDR_W-1:0] gpu_vaddr,
  input  logic [ADDR_W-1:0] gpu_haddr,
  output logic [DATA_W-1:0] gpu_rdata,
  output logic              gpu_rvalid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_vaddr,
  input  logic [ADDR_W-1:0] cpu_haddr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              collapse_start,
  input  logic [ADDR_W-1:0] collapse_row,
  output logic              collapse_busy,
  output logic              collapse_done,
  output logic [ADDR_W-1:0] mem_vaddr,
  output logic [ADDR_W-1:0] mem_haddr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_CLR, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  state_t              state;
  logic [ADDR_W-1:0]   row;
  logic [ADDR_W-1:0]   col;
  logic [DATA_W-1:0]   held_data;
  logic                gpu_tag;
  logic                cpu_tag;
  logic                eng_port;

  assign eng_port = (state == S_RD) || (state == S_WR) || (state == S_CLR);

  // No CPU traffic while reset is held, so a request pending across reset cannot write.
  assign cpu_gnt = reset && !gpu_rd_en && !eng_port && cpu_req &&
                   !collapse_busy && !collapse_start;

  always_comb begin
    mem_vaddr = '0;
    mem_haddr = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (gpu_rd_en) begin
      mem_vaddr = gpu_vaddr;
      mem_haddr = gpu_haddr;
    end else if (eng_port) begin
      case (state)
        S_RD: begin
          mem_vaddr = row - ONE;
          mem_haddr = col;
        end
        S_WR: begin
          mem_vaddr = row;
          mem_haddr = col;
          mem_we    = 1'b1;
          mem_wdata = held_data;
        end
        default: begin
          mem_haddr = col;
          mem_we    = 1'b1;
        end
      endcase
    end else if (cpu_gnt) begin
      mem_vaddr = cpu_vaddr;
      mem_haddr = cpu_haddr;
      mem_we    = cpu_we;
      mem_wdata = cpu_wdata;
    end
  end

  // Collapse engine: copy row r-1 into row r column by column, walking r up to the top,
  // then blank row 0. Port-using states simply stall whenever the GPU is reading.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      row           <= '0;
      col           <= '0;
      held_data     <= '0;
      collapse_busy <= 1'b0;
      collapse_done <= 1'b0;
    end else begin
      collapse_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (collapse_start) begin
            if (int'(collapse_row) < ROWS) begin
              row           <= collapse_row;
              col           <= '0;
              collapse_busy <= 1'b1;
              state         <= (collapse_row == '0) ? S_CLR : S_RD;
            end else begin
              collapse_done <= 1'b1;
              state         <= S_DONE;
            end
          end
        end
        S_RD: begin
          if (!gpu_rd_en) state <= S_WAIT;
        end
        S_WAIT: begin
          held_data <= mem_rdata;
          state     <= S_WR;
        end
        S_WR: begin
          if (!gpu_rd_en) begin
            if (col != LAST_COL) begin
              col   <= col + ONE;
              state <= S_RD;
            end else begin
              col   <= '0;
              row   <= row - ONE;
              state <= (row == ONE) ? S_CLR : S_RD;
            end
          end
        end
        S_CLR: begin
          if (!gpu_rd_en) begin
            if (col == LAST_COL) begin
              col           <= '0;
              collapse_busy <= 1'b0;
              collapse_done <= 1'b1;
              state         <= S_DONE;
            end else begin
              col <= col + ONE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Two-stage read return: tag at issue, data registered the cycle mem_rdata is valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpu_tag    <= 1'b0;
      cpu_tag    <= 1'b0;
      gpu_rvalid <= 1'b0;
      cpu_rvalid <= 1'b0;
      gpu_rdata  <= '0;
      cpu_rdata  <= '0;
    end else begin
      gpu_tag    <= gpu_rd_en;
      cpu_tag    <= cpu_gnt && !cpu_we;
      gpu_rvalid <= gpu_tag;
      cpu_rvalid <= cpu_tag;
      if (gpu_tag) gpu_rdata <= mem_rdata;
      if (cpu_tag) cpu_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Testbench for board_mem_arbiter: a behavioural board memory plus a reference board
// array that models CPU writes and row collapses at whole-row level.
module tb_board_mem_arbiter;

  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int AW   = 5;
  localparam int DW   = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          gpu_rd_en;
  logic [AW-1:0] gpu_vaddr, gpu_haddr;
  logic [DW-1:0] gpu_rdata;
  logic          gpu_rvalid;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_vaddr, cpu_haddr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;
  logic          collapse_start;
  logic [AW-1:0] collapse_row;
  logic          collapse_busy, collapse_done;
  logic [AW-1:0] mem_vaddr, mem_haddr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] board     [0:31][0:31];
  logic [DW-1:0] ref_board [0:ROWS-1][0:COLS-1];
  logic          tb_clear;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  board_mem_arbiter #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .gpu_rd_en(gpu_rd_en), .gpu_vaddr(gpu_vaddr), .gpu_haddr(gpu_haddr),
    .gpu_rdata(gpu_rdata), .gpu_rvalid(gpu_rvalid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_vaddr(cpu_vaddr), .cpu_haddr(cpu_haddr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .collapse_start(collapse_start), .collapse_row(collapse_row),
    .collapse_busy(collapse_busy), .collapse_done(collapse_done),
    .mem_vaddr(mem_vaddr), .mem_haddr(mem_haddr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous-read board memory: data for a read issued in cycle N is on mem_rdata in N+1.
  always @(posedge clk) begin
    if (tb_clear) begin
      for (int i = 0; i < 32; i++)
        for (int j = 0; j < 32; j++) board[i][j] <= '0;
      mem_rdata <= '0;
    end else begin
      mem_rdata <= board[mem_vaddr][mem_haddr];
      if (mem_we) board[mem_vaddr][mem_haddr] <= mem_wdata;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ref_collapse(input int r);
    if (r < ROWS) begin
      for (int y = r; y > 0; y--)
        for (int x = 0; x < COLS; x++) ref_board[y][x] = ref_board[y-1][x];
      for (int x = 0; x < COLS; x++) ref_board[0][x] = '0;
    end
  endtask

  task automatic cpu_write(input logic [AW-1:0] v, input logic [AW-1:0] h, input logic [DW-1:0] d);
    int n = 0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_vaddr = v; cpu_haddr = h; cpu_wdata = d;
    #1;
    while (!cpu_gnt && n < 2000) begin
      cyc(); #1; n++;
    end
    checks++;
    if (cpu_gnt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL cpu_write_gnt: gnt=%b required 1 for (%0d,%0d)", cpu_gnt, v, h);
    end else begin
      ref_board[v][h] = d;
    end
    cyc();
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic fill_random();
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        cpu_write(AW'(y), AW'(x), DW'($urandom_range(0, 7)));
  endtask

  // Back-to-back GPU reads of every cell; returns mismatch count and first bad cell.
  task automatic read_board_gpu(output int errs, output int got, output int bv, output int bh,
                                output int bgot, output int bexp);
    int q[$];
    int idx;
    errs = 0; got = 0; bv = -1; bh = -1; bgot = -1; bexp = -1;
    for (int k = 0; k < ROWS*COLS + 2; k++) begin
      if (k < ROWS*COLS) begin
        gpu_rd_en = 1'b1; gpu_vaddr = AW'(k / COLS); gpu_haddr = AW'(k % COLS);
        q.push_back(k);
      end else begin
        gpu_rd_en = 1'b0;
      end
      #1;
      if (gpu_rvalid) begin
        if (q.size() == 0) begin
          errs++;
        end else begin
          idx = q.pop_front();
          got++;
          if (gpu_rdata !== ref_board[idx / COLS][idx % COLS]) begin
            if (errs == 0) begin
              bv = idx / COLS; bh = idx % COLS;
              bgot = int'(gpu_rdata); bexp = int'(ref_board[idx / COLS][idx % COLS]);
            end
            errs++;
          end
        end
      end
      cyc();
    end
    gpu_rd_en = 1'b0;
  endtask

  // Runs one collapse with optional random GPU traffic and an optional competing CPU write.
  task automatic run_collapse(input logic [AW-1:0] row, input bit gpu_mode, input bit cpu_mode,
                              input logic [AW-1:0] cv, input logic [AW-1:0] ch, input logic [DW-1:0] cd,
                              output int cycles, output int gnt_cycle, output int gnt_busy,
                              output int lat_err, output int we_count, output int busy_low);
    logic d1 = 1'b0;
    logic d2 = 1'b0;
    bit   done_seen = 1'b0;
    int   n = 0;
    cycles = -1; gnt_cycle = -1; gnt_busy = 0; lat_err = 0; we_count = 0; busy_low = 0;
    collapse_start = 1'b1; collapse_row = row;
    if (cpu_mode) begin
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_vaddr = cv; cpu_haddr = ch; cpu_wdata = cd;
    end
    while (n < 3000) begin
      if (gpu_mode && !done_seen) begin
        gpu_rd_en = 1'($urandom_range(0, 1));
        gpu_vaddr = AW'($urandom_range(0, ROWS-1));
        gpu_haddr = AW'($urandom_range(0, COLS-1));
      end else begin
        gpu_rd_en = 1'b0;
      end
      #1;
      if (gpu_rvalid !== d2) lat_err++;
      d2 = d1; d1 = gpu_rd_en;
      if (mem_we) we_count++;
      if (cpu_gnt && collapse_busy) gnt_busy++;
      if (cpu_req && cpu_gnt && gnt_cycle < 0) gnt_cycle = n;
      if (n > 0 && !done_seen && !collapse_busy && !collapse_done) busy_low++;
      if (collapse_done && !done_seen) begin
        done_seen = 1'b1; cycles = n;
      end
      if (done_seen && (!cpu_mode || gnt_cycle >= 0)) break;
      cyc();
      n++;
      collapse_start = 1'b0;
      if (gnt_cycle >= 0) cpu_req = 1'b0;
    end
    cyc();
    collapse_start = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; gpu_rd_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      if (gpu_rvalid !== d2) lat_err++;
      d2 = d1; d1 = 1'b0;
      cyc();
    end
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    #1;
    obs = {gpu_rvalid, cpu_rvalid, collapse_busy, collapse_done, gpu_rdata, cpu_rdata, mem_we, cpu_gnt};
    checks++;
    if (obs !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h required 000", obs);
    end
    cyc();
    reset = 1'b1;
    tb_clear = 1'b0;
    #1;
    checks++;
    if ({mem_vaddr, mem_haddr, mem_we, cpu_gnt, collapse_busy} !== 13'h0) begin
      errors++;
      $display("[TB] FAIL idle_port: vaddr=%0d haddr=%0d we=%b gnt=%b busy=%b required all 0",
               mem_vaddr, mem_haddr, mem_we, cpu_gnt, collapse_busy);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    int errs, got, bv, bh, bgot, bexp;
    fill_random();
    read_board_gpu(errs, got, bv, bh, bgot, bexp);
    checks++;
    if (got !== ROWS*COLS) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d returns required %0d", got, ROWS*COLS);
    end
    checks++;
    if (errs !== 0) begin
      errors++;
      $display("[TB] FAIL b2b_data: %0d bad, (%0d,%0d) got %0d required %0d", errs, bv, bh, bgot, bexp);
    end
  endtask

  task automatic test_gpu_read();
    logic [AW-1:0] v, h;
    cpu_write(5'd3, 5'd4, 3'd5);
    for (int t = 0; t < 9; t++) begin
      v = (t == 0) ? 5'd3 : AW'($urandom_range(0, ROWS-1));
      h = (t == 0) ? 5'd4 : AW'($urandom_range(0, COLS-1));
      gpu_rd_en = 1'b1; gpu_vaddr = v; gpu_haddr = h;
      cyc();
      gpu_rd_en = 1'b0;
      #1;
      checks++;
      if (gpu_rvalid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL gpu_early_rvalid: got %b required 0 (read %0d)", gpu_rvalid, t);
      end
      cyc(); #1;
      checks++;
      if (gpu_rvalid !== 1'b1 || gpu_rdata !== ref_board[v][h] || cpu_rvalid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL gpu_read: (%0d,%0d) rvalid=%b rdata=%0d cpu_rvalid=%b required 1,%0d,0",
                 v, h, gpu_rvalid, gpu_rdata, cpu_rvalid, ref_board[v][h]);
      end
      cyc(); #1;
      checks++;
      if (gpu_rvalid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL gpu_rvalid_pulse: got %b required 0", gpu_rvalid);
      end
      cyc();
    end
  endtask

  task automatic test_gpu_priority();
    int bad = 0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_vaddr = 5'd7; cpu_haddr = 5'd2; cpu_wdata = 3'd6;
    for (int t = 0; t < 10; t++) begin
      gpu_rd_en = 1'b1;
      gpu_vaddr = AW'($urandom_range(0, ROWS-1));
      gpu_haddr = AW'($urandom_range(0, COLS-1));
      #1;
      if (cpu_gnt !== 1'b0 || mem_we !== 1'b0) bad++;
      cyc();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("[TB] FAIL gpu_blocks_cpu: %0d cycles with gnt or we set, required 0", bad);
    end
    gpu_rd_en = 1'b0;
    #1;
    checks++;
    if (cpu_gnt !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 3'd6 || mem_vaddr !== 5'd7 || mem_haddr !== 5'd2) begin
      errors++;
      $display("[TB] FAIL cpu_gnt_after_gpu: gnt=%b we=%b wdata=%0d addr=(%0d,%0d) required 1,1,6,(7,2)",
               cpu_gnt, mem_we, mem_wdata, mem_vaddr, mem_haddr);
    end else begin
      ref_board[7][2] = 3'd6;
    end
    cyc();
    cpu_req = 1'b0; cpu_we = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic test_cpu_random();
    logic [AW-1:0] v, h;
    for (int t = 0; t < 24; t++) begin
      v = AW'($urandom_range(0, ROWS-1));
      h = AW'($urandom_range(0, COLS-1));
      if ($urandom_range(0, 1) == 1) begin
        cpu_write(v, h, DW'($urandom_range(0, 7)));
      end else begin
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_vaddr = v; cpu_haddr = h;
        #1;
        checks++;
        if (cpu_gnt !== 1'b1 || mem_we !== 1'b0) begin
          errors++;
          $display("[TB] FAIL cpu_read_gnt: gnt=%b we=%b required 1,0", cpu_gnt, mem_we);
        end
        cyc();
        cpu_req = 1'b0;
        #1;
        checks++;
        if (cpu_rvalid !== 1'b0) begin
          errors++;
          $display("[TB] FAIL cpu_early_rvalid: got %b required 0", cpu_rvalid);
        end
        cyc(); #1;
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== ref_board[v][h] || gpu_rvalid !== 1'b0) begin
          errors++;
          $display("[TB] FAIL cpu_read: (%0d,%0d) rvalid=%b rdata=%0d gpu_rvalid=%b required 1,%0d,0",
                   v, h, cpu_rvalid, cpu_rdata, gpu_rvalid, ref_board[v][h]);
        end
        cyc();
      end
    end
  endtask

  task automatic load_three_rows();
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < COLS; x++) cpu_write(AW'(y), AW'(x), DW'(y + 1));
  endtask

  task automatic check_board(input string name);
    int errs, got, bv, bh, bgot, bexp;
    read_board_gpu(errs, got, bv, bh, bgot, bexp);
    checks++;
    if (errs !== 0 || got !== ROWS*COLS) begin
      errors++;
      $display("[TB] FAIL %s_board: %0d bad of %0d, (%0d,%0d) got %0d required %0d",
               name, errs, got, bv, bh, bgot, bexp);
    end
  endtask

  task automatic test_collapse();
    int cycles, gc, gb, le, wc, bl;
    load_three_rows();
    run_collapse(5'd2, 1'b0, 1'b0, '0, '0, '0, cycles, gc, gb, le, wc, bl);
    checks++;
    if (cycles !== 3*COLS*2 + COLS + 1 || bl !== 0) begin
      errors++;
      $display("[TB] FAIL collapse_timing: done after %0d cycles, busy low %0d, required %0d and 0",
               cycles, bl, 3*COLS*2 + COLS + 1);
    end
    ref_collapse(2);
    check_board("collapse");
  endtask

  task automatic test_collapse_gpu();
    int cycles, gc, gb, le, wc, bl;
    logic [AW-1:0] cv, ch;
    logic [DW-1:0] cd;
    load_three_rows();
    cv = AW'($urandom_range(3, ROWS-1)); ch = AW'($urandom_range(0, COLS-1)); cd = DW'($urandom_range(0, 7));
    run_collapse(5'd2, 1'b1, 1'b1, cv, ch, cd, cycles, gc, gb, le, wc, bl);
    checks++;
    if (cycles < 3*COLS*2 + COLS + 1 || bl !== 0) begin
      errors++;
      $display("[TB] FAIL collapse_gpu_timing: done after %0d cycles, busy low %0d, required >= %0d and 0",
               cycles, bl, 3*COLS*2 + COLS + 1);
    end
    checks++;
    if (le !== 0) begin
      errors++;
      $display("[TB] FAIL collapse_gpu_latency: %0d rvalid errors, required 0", le);
    end
    checks++;
    if (gb !== 0 || gc < cycles) begin
      errors++;
      $display("[TB] FAIL collapse_gpu_cpu_hold: gnt while busy %0d, gnt cycle %0d, done cycle %0d",
               gb, gc, cycles);
    end
    ref_collapse(2);
    ref_board[cv][ch] = cd;
    check_board("collapse_gpu");
  endtask

  task automatic test_start_vs_cpu();
    int cycles, gc, gb, le, wc, bl;
    int r;
    logic [AW-1:0] cv, ch;
    logic [DW-1:0] cd;
    r  = $urandom_range(1, 6);
    cv = AW'($urandom_range(0, ROWS-1)); ch = AW'($urandom_range(0, COLS-1)); cd = DW'($urandom_range(0, 7));
    run_collapse(AW'(r), 1'b0, 1'b1, cv, ch, cd, cycles, gc, gb, le, wc, bl);
    checks++;
    if (cycles !== 3*COLS*r + COLS + 1) begin
      errors++;
      $display("[TB] FAIL start_vs_cpu_timing: row %0d done after %0d required %0d", r, cycles, 3*COLS*r + COLS + 1);
    end
    checks++;
    if (gb !== 0 || gc < cycles) begin
      errors++;
      $display("[TB] FAIL start_vs_cpu_gnt: gnt while busy %0d, gnt cycle %0d, done cycle %0d", gb, gc, cycles);
    end
    ref_collapse(r);
    ref_board[cv][ch] = cd;
    check_board("start_vs_cpu");
    run_collapse(5'd25, 1'b0, 1'b0, '0, '0, '0, cycles, gc, gb, le, wc, bl);
    checks++;
    if (cycles !== 1 || wc !== 0 || bl !== 0) begin
      errors++;
      $display("[TB] FAIL collapse_out_of_range: done after %0d, writes %0d, busy low %0d required 1,0,0",
               cycles, wc, bl);
    end
  endtask

  task automatic test_reset_mid();
    int cycles, gc, gb, le, wc, bl;
    int bad = 0;
    collapse_start = 1'b1; collapse_row = 5'd5;
    cyc();
    collapse_start = 1'b0;
    repeat ($urandom_range(20, 80)) cyc();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_vaddr = 5'd1; cpu_haddr = 5'd1; cpu_wdata = 3'd7;
    gpu_rd_en = 1'b1;
    cyc();
    #1;
    checks++;
    if (collapse_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mid_busy_before: got %b required 1", collapse_busy);
    end
    cyc();
    gpu_rd_en = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if ({collapse_busy, cpu_gnt, gpu_rvalid, cpu_rvalid, mem_we, collapse_done} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid: busy=%b gnt=%b grv=%b crv=%b we=%b done=%b required all 0",
               collapse_busy, cpu_gnt, gpu_rvalid, cpu_rvalid, mem_we, collapse_done);
    end
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      if (collapse_done !== 1'b0 || mem_we !== 1'b0 || cpu_gnt !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_hold: %0d cycles with activity during reset, required 0", bad);
    end
    cyc();
    cpu_req = 1'b0; cpu_we = 1'b0;
    reset = 1'b1;
    cyc();
    fill_random();
    run_collapse(5'd5, 1'b0, 1'b0, '0, '0, '0, cycles, gc, gb, le, wc, bl);
    checks++;
    if (cycles !== 3*COLS*5 + COLS + 1) begin
      errors++;
      $display("[TB] FAIL reset_mid_recover: done after %0d required %0d", cycles, 3*COLS*5 + COLS + 1);
    end
    ref_collapse(5);
    check_board("reset_mid");
  endtask

  initial begin
    reset = 1'b0; tb_clear = 1'b1;
    gpu_rd_en = 1'b0; gpu_vaddr = '0; gpu_haddr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_vaddr = '0; cpu_haddr = '0; cpu_wdata = '0;
    collapse_start = 1'b0; collapse_row = '0;
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) ref_board[y][x] = '0;
    repeat (3) cyc();
    test_reset();
    test_back_to_back();
    test_gpu_read();
    test_gpu_priority();
    test_cpu_random();
    test_collapse();
    test_collapse_gpu();
    test_start_vs_cpu();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
